// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD adder controller.
package bcd_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder slice: binary add then decimal correction when the sum exceeds 9.
module bcd_digit_add
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    digit = t[3:0];
    cout  = 1'b0;
    // Adding 6 modulo 16 also gives a defined result for invalid digits.
    if (t > {1'b0, BCD_MAX}) begin
      digit = t[3:0] + BCD_CORR;
      cout  = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Adds two packed BCD operands one digit per clock through a single shared slice.
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned IDXW   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Cin,
  output logic [4*DIGITS-1:0]   Sum,
  output logic                  Cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned W = 4 * DIGITS;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic            carry;
  logic [IDXW-1:0] index;
  logic [3:0]      digit;
  logic            slice_cout;
  logic            last;

  // Operands shift right so the current digit is always in the low nibble.
  bcd_digit_add u_slice (
    .a     (a_sh[3:0]),
    .b     (b_sh[3:0]),
    .cin   (carry),
    .digit (digit),
    .cout  (slice_cout)
  );

  assign last = (index == IDXW'(DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      index <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            index <= '0;
            Sum   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= ST_ADD;
          end
        end
        ST_ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (index == IDXW'(i)) Sum[4*i +: 4] <= digit;
          end
          carry <= slice_cout;
          err   <= err | (a_sh[3:0] > BCD_MAX) | (b_sh[3:0] > BCD_MAX);
          index <= index + IDXW'(1);
          a_sh  <= {4'b0, a_sh[W-1:4]};
          b_sh  <= {4'b0, b_sh[W-1:4]};
          if (last) begin
            Cout  <= slice_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: vector table, corner sequences, random ops.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         busy;
  logic         done;
  logic         err;

  bcd_serial_add_ctrl #(
    .DIGITS (DIGITS),
    .IDXW   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Sum   (Sum),
    .Cout  (Cout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    bit           spam;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // One operation: push expectation, start, then watch DIGITS+2 cycles for the single done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic ee,
                        input bit spam, input bit full, input string tag);
    exp_t e;
    exp_t got;
    int   lat;
    e.sum = es;
    e.cout = ec;
    e.err = ee;
    sb.push_back(e);
    @(negedge clk);
    A = a;
    B = b;
    Cin = cin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = spam;
    A = rand_bcd();
    B = ~a;
    Cin = ~cin;
    lat = -1;
    for (int j = 0; j <= DIGITS + 1; j++) begin
      @(negedge clk);
      if (full) begin
        check({tag, " busy"}, W'(busy), W'(j < DIGITS));
        check({tag, " done"}, W'(done), W'(j == DIGITS));
      end
      if (done === 1'b1 && lat < 0) begin
        lat = j;
        if (sb.size() == 0) begin
          check({tag, " unexpected done"}, W'(1), W'(0));
        end else begin
          got = sb.pop_front();
          check({tag, " Sum"}, Sum, got.sum);
          check({tag, " Cout"}, W'(Cout), W'(got.cout));
          check({tag, " err"}, W'(err), W'(got.err));
        end
      end
      if (spam && j < DIGITS) begin
        start = 1'b1;
        A = rand_bcd();
        B = rand_bcd();
        Cin = 1'(j);
      end else begin
        start = 1'b0;
      end
    end
    check({tag, " latency"}, W'(lat), W'(DIGITS));
    if (lat < 0 && sb.size() != 0) void'(sb.pop_front());
  endtask

  vec_t vecs[$];

  initial begin
    int ndone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           s;

    vecs.push_back('{16'h0100, 16'h0017, 1'b0, 16'h0117, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h0999, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h5555, 16'h4444, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'hF000, 16'h0000, 1'b0, 16'h5000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{16'h0321, 16'h0456, 1'b0, 16'h0777, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h4999, 16'h0000, 1'b1, 16'h5000, 1'b0, 1'b0, 1'b1});

    #12;
    check("reset Sum", Sum, '0);
    check("reset Cout", W'(Cout), '0);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset err", W'(err), '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].err,
             vecs[i].spam, 1'b1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d hold Sum", i), Sum, vecs[i].sum);
    end

    // start held high continuously: back-to-back ops, one done per DIGITS+2 cycles.
    @(negedge clk);
    A = 16'h0025;
    B = 16'h0017;
    Cin = 1'b0;
    start = 1'b1;
    ndone = 0;
    for (int j = 0; j < 3 * (DIGITS + 2); j++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    check("held start done count", W'(ndone), W'(3));
    check("held start Sum", Sum, 16'h0042);
    @(negedge clk);
    @(negedge clk);
    check("held start idle busy", W'(busy), '0);

    // Asynchronous reset after two digits have been processed.
    @(negedge clk);
    A = 16'h1111;
    B = 16'h1111;
    Cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("partial Sum", Sum, 16'h0022);
    #2 reset = 1'b1;
    #1;
    check("abort Sum", Sum, '0);
    check("abort busy", W'(busy), '0);
    check("abort done", W'(done), '0);
    check("abort err", W'(err), '0);
    ndone = 0;
    for (int j = 0; j < DIGITS + 2; j++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (j == 1) reset = 1'b0;
    end
    check("abort no done", W'(ndone), '0);
    run_op(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, "post-reset");

    // Random valid operations against a decimal reference model.
    for (int n = 0; n < 500; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rc = 1'($urandom_range(0, 1));
      s = bcd_to_int(ra) + bcd_to_int(rb) + int'(rc);
      run_op(ra, rb, rc, int_to_bcd(s % 10000), s >= 10000, 1'b0, 1'b0, 1'b0,
             $sformatf("rand%0d", n));
    end

    check("scoreboard drained", W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Sequencing controller that adds two packed multi-digit BCD operands, one decimal digit per clock.
- Time-shares a single one-digit BCD adder slice across all digits.
- Sits between a requesting block (start/operands) and downstream logic that consumes the packed BCD sum on a done pulse.
- Replaces a wide combinational BCD adder with a small, area-cheap sequenced datapath.

Parameters:
- DIGITS, 4, number of BCD digits per operand (sum width = 4*DIGITS bits); legal range 2..16.
- IDXW, 4, width of the internal digit index; must satisfy 2**IDXW >= DIGITS.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0].
- B  input  4*DIGITS  operand B, packed BCD.
- Cin  input  1  decimal carry-in to digit 0.
- Sum  output  4*DIGITS  packed BCD result register.
- Cout  output  1  decimal carry-out of the most-significant digit.
- busy  output  1  high while digits are being processed (ADD state).
- done  output  1  one-cycle pulse when Sum/Cout become valid.
- err  output  1  an operand digit > 9 was seen in the current operation.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state = IDLE; Sum = 0; Cout = 0; busy = 0; done = 0; err = 0; carry = 0; index = 0.
- Reset mid-operation aborts immediately. No done pulse is issued, and Sum is cleared.
- States: IDLE, ADD, DONE.
- IDLE behaviour:
  - On an edge with start = 1: latch A, B into operand shift registers; carry <= Cin; index <= 0; Sum <= 0; err <= 0; go to ADD.
  - busy rises with the state change.
- ADD behaviour: each edge processes digit[index] through the slice.
  - Write the digit result into Sum[4*index +: 4].
  - carry <= slice carry-out.
  - err <= err | (A digit > 9) | (B digit > 9).
  - index <= index + 1.
  - After processing index = DIGITS-1: Cout <= slice carry-out; go to DONE.
- DONE behaviour: done = 1 and busy = 0 for exactly one cycle, then unconditional return to IDLE.
- Latency: start sampled at edge k. Digits are processed at edges k+1 .. k+DIGITS. done is high in the cycle following edge k+DIGITS.
- Throughput: one operation per DIGITS+2 cycles.
- Sum, Cout and err hold their values after done until the next accepted start.
- start is ignored in ADD and DONE; no queuing. Operand changes after the accepting edge have no effect.
- Slice arithmetic, for each digit:
  - t = a + b + c, computed 5 bits wide.
  - If t > 9: digit = (t + 6) mod 16, carry = 1.
  - Otherwise: digit = t, carry = 0.
- Invalid digits (10..15) use the same rule. The result is defined but flagged by err; err is sticky for the operation.
- Max legal case 9+9+1 = 19 -> digit 9, carry 1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE = 2'd0, ST_ADD = 2'd1, ST_DONE = 2'd2;
  - BCD constants BCD_MAX = 4'd9 and BCD_CORR = 4'd6.
- One natural sub-module: bcd_digit_add. It is purely combinational, with 4-bit a, 4-bit b, 1-bit cin in, and 4-bit digit, 1-bit cout out.
- The controller instantiates it exactly once.

Test Plan:
- DIGITS=4, A=0x0100, B=0x0017, Cin=0, start at edge 0 -> Sum=0x0117, Cout=0, err=0; busy high during cycles 1-4; done pulses in cycle 5 only.
- A=0x9999, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, err=0. A=0x0999, B=0x0001, Cin=1 -> Sum=0x1001, Cout=0.
- A=0x00A0, B=0x0000, Cin=0 -> Sum=0x0100, Cout=0, err=1. A following valid operation clears err to 0.
- start re-asserted every cycle with changing operands during ADD/DONE -> ignored. Result matches the first accepted operands, and exactly one done is seen per DIGITS+2 cycles.
- Assert reset asynchronously (between edges) in the middle of ADD (after 2 digits) -> all outputs are 0 immediately and no done appears. A start after release completes normally: 0x1234 + 0x8766 -> Sum=0x0000, Cout=1.
- Randomised: 500 operations with valid digits and random Cin, compared against a decimal reference model -> Sum/Cout match, err=0, and done latency is exactly DIGITS+1 cycles after the start edge.
